// File: rtl/muldiv_if.sv
// Issue/result bundle between decode/execute and the RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned LEN = 32
);
    logic           start;
    logic [2:0]     op;
    logic [LEN-1:0] op1;
    logic [LEN-1:0] op2;
    logic           flush;
    logic           busy;
    logic           done;
    logic [LEN-1:0] result;

    // Pipeline side issues work and observes status.
    modport master (
        output start, op, op1, op2, flush,
        input  busy, done, result
    );

    // Unit side consumes requests and drives status.
    modport slave (
        input  start, op, op1, op2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// LEN iterations on operand magnitudes plus one sign fix-up cycle.
module muldiv_unit #(
    parameter int unsigned LEN = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned PW = 2 * LEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [LEN-1:0] MIN_NEG = {1'b1, {(LEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e          state_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            div0_q;
    logic            ovf_q;
    logic [CW-1:0]   cnt_q;
    logic [LEN-1:0]  mcand_q;   // multiplicand / divisor magnitude
    logic [LEN-1:0]  op1_q;     // raw rs1, returned by remainder-by-zero
    logic [PW-1:0]   acc_q;     // product accumulator, multiplier in low half
    logic [LEN-1:0]  quo_q;     // dividend shifting out, quotient shifting in
    logic [LEN:0]    rem_q;
    logic [LEN-1:0]  result_q;
    logic            busy_q;
    logic            done_q;

    logic            sgn1;
    logic            sgn2;
    logic [LEN-1:0]  mag1_d;
    logic [LEN-1:0]  mag2_d;
    logic            neg_d;
    logic            div0_d;
    logic            ovf_d;
    logic [LEN:0]    mul_sum;
    logic [PW-1:0]   acc_d;
    logic [LEN:0]    rem_sh;
    logic [LEN:0]    trial;
    logic [LEN:0]    rem_d;
    logic [LEN-1:0]  quo_d;
    logic [PW-1:0]   prod_f;
    logic [LEN-1:0]  quo_f;
    logic [LEN-1:0]  rem_f;
    logic [LEN-1:0]  result_d;

    // Request decode: operand signedness, magnitudes, negate flag, special cases.
    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        neg_d = 1'b0;
        unique case (bus.op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1 = bus.op1[LEN-1];
                sgn2 = bus.op2[LEN-1];
            end
            OP_MULHSU: sgn1 = bus.op1[LEN-1];
            default: ;
        endcase
        unique case (bus.op)
            OP_MULH, OP_DIV:   neg_d = sgn1 ^ sgn2;
            OP_MULHSU, OP_REM: neg_d = sgn1;
            default:           neg_d = 1'b0;
        endcase
        mag1_d = sgn1 ? -bus.op1 : bus.op1;
        mag2_d = sgn2 ? -bus.op2 : bus.op2;
        div0_d = bus.op[2] && (bus.op2 == '0);
        ovf_d  = bus.op[2] && !bus.op[0] && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
    end

    // One multiply step and one restoring-divide step per CALC cycle.
    always_comb begin
        mul_sum = {1'b0, acc_q[PW-1:LEN]} + {1'b0, mcand_q};
        acc_d   = acc_q[0] ? {mul_sum, acc_q[LEN-1:1]} : {1'b0, acc_q[PW-1:1]};
        rem_sh  = {rem_q[LEN-1:0], quo_q[LEN-1]};
        trial   = rem_sh - {1'b0, mcand_q};
        if (!trial[LEN]) begin
            rem_d = trial;
            quo_d = {quo_q[LEN-2:0], 1'b1};
        end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[LEN-2:0], 1'b0};
        end
    end

    // Sign fix-up, half selection and special-case override.
    always_comb begin
        prod_f   = neg_q ? -acc_q : acc_q;
        quo_f    = neg_q ? -quo_q : quo_q;
        rem_f    = neg_q ? -rem_q[LEN-1:0] : rem_q[LEN-1:0];
        result_d = prod_f[LEN-1:0];
        unique case (op_q)
            OP_MUL:                      result_d = prod_f[LEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_f[PW-1:LEN];
            OP_DIV, OP_DIVU:             result_d = div0_q ? '1 : (ovf_q ? MIN_NEG : quo_f);
            OP_REM, OP_REMU:             result_d = div0_q ? op1_q : (ovf_q ? '0 : rem_f);
            default:                     result_d = prod_f[LEN-1:0];
        endcase
    end

    // Control FSM and datapath registers; flush beats start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            op1_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.flush) begin
                        op_q    <= bus.op;
                        neg_q   <= neg_d;
                        div0_q  <= div0_d;
                        ovf_q   <= ovf_d;
                        op1_q   <= bus.op1;
                        mcand_q <= mag2_d;
                        acc_q   <= {LEN'(0), mag1_d};
                        quo_q   <= mag1_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(LEN - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus cycle-level timing expectations.
module tb_muldiv_unit;
    localparam int unsigned LEN = 32;
    localparam int BIG = 1 << 30;

    typedef struct {
        int          k;       // accept edge; busy seen at cyc k..k+LEN, done at k+LEN+1
        logic [31:0] res;
        int          end_at;  // last cycle the op is alive (flush/reset), BIG if never cut
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_if #(.LEN(LEN)) bus ();
    muldiv_unit #(.LEN(LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rec_t        ops[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] res_exp = '0;

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of busy/done/result against the timing model.
    task automatic check_cycle();
        logic eb, ed;
        eb = 1'b0;
        ed = 1'b0;
        if (rst) begin
            res_exp = '0;
        end else begin
            foreach (ops[i]) begin
                if (ops[i].k <= cyc && cyc <= ops[i].k + LEN && cyc <= ops[i].end_at) eb = 1'b1;
                if (cyc == ops[i].k + LEN + 1 && ops[i].end_at >= cyc) begin
                    ed = 1'b1;
                    res_exp = ops[i].res;
                end
            end
        end
        cmp("busy", 32'(bus.busy), 32'(eb));
        cmp("done", 32'(bus.done), 32'(ed));
        cmp("result", bus.result, res_exp);
    endtask

    task automatic scramble();
        bus.op  = 3'($urandom);
        bus.op1 = $urandom;
        bus.op2 = $urandom;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        if (!bus.start) scramble();
    endtask

    // Issue one op; called right after a tick while the unit is IDLE or DONE.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int idx);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op1   = a;
        bus.op2   = b;
        ops.push_back('{cyc + 1, ref_res(op, a, b), BIG});
        idx = ops.size() - 1;
        tick();
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic finish_op(input int idx);
        while (cyc < ops[idx].k + LEN + 1) tick();
    endtask

    task automatic run_dir(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int idx;
        cmp({name, " model"}, ref_res(op, a, b), exp);
        issue(op, a, b, idx);
        finish_op(idx);
        cmp(name, bus.result, exp);
    endtask

    initial begin
        int idx, nb, fm;
        logic [2:0] op;
        logic [31:0] a, b;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        scramble();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // MUL 7 x -3 with busy width
        cmp("MUL model", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, idx);
        nb = bus.busy ? 1 : 0;
        while (cyc < ops[idx].k + LEN + 1) begin
            tick();
            if (bus.busy) nb++;
        end
        cmp("MUL result", bus.result, 32'hFFFF_FFEB);
        cmp("MUL busy cycles", 32'(nb), 32'(LEN + 1));

        run_dir("MULHU -1*-1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_dir("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_dir("MULHSU -1*-1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_dir("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_dir("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_dir("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_dir("DIVU big/2", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run_dir("REMU big/2", 3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
        run_dir("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_dir("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5);
        run_dir("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        tick();

        // start held high: one accept every LEN+2 cycles, operands changing throughout
        bus.start = 1'b1;
        for (int m = 0; m < 3 * (LEN + 2); m++) begin
            op = 3'($urandom);
            a  = pick();
            b  = pick();
            bus.op  = op;
            bus.op1 = a;
            bus.op2 = b;
            if (m % (LEN + 2) == 0) ops.push_back('{cyc + 1, ref_res(op, a, b), BIG});
            tick();
        end
        bus.start = 1'b0;
        repeat (2) tick();

        // flush at cycle k+10 of a CALC
        issue(3'd0, 32'd1234, 32'd5678, idx);
        while (cyc < ops[idx].k + 9) tick();
        bus.flush = 1'b1;
        ops[idx].end_at = cyc;
        tick();
        bus.flush = 1'b0;
        repeat (2) tick();

        // flush in FIX
        issue(3'd5, 32'd1000, 32'd3, idx);
        while (cyc < ops[idx].k + LEN) tick();
        bus.flush = 1'b1;
        ops[idx].end_at = cyc;
        tick();
        bus.flush = 1'b0;
        tick();

        // flush with start in DONE: done still pulses, no new op
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, idx);
        finish_op(idx);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        ops[idx].end_at = cyc;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        tick();

        // flush with start in IDLE: not accepted
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (2) tick();

        // randomized ops, gaps, back-to-back issue and random aborts
        for (int n = 0; n < 100; n++) begin
            issue(3'($urandom), pick(), pick(), idx);
            if ($urandom_range(0, 9) == 0) begin
                fm = ops[idx].k + int'($urandom_range(0, LEN));
                while (cyc < fm) tick();
                bus.flush = 1'b1;
                ops[idx].end_at = cyc;
                tick();
                bus.flush = 1'b0;
            end else begin
                finish_op(idx);
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        repeat (2) tick();

        // async reset mid-CALC, then recovery
        run_dir("MUL pre-reset", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        issue(3'd4, 32'd999, 32'd7, idx);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        cmp("rst busy", 32'(bus.busy), 32'd0);
        cmp("rst done", 32'(bus.done), 32'd0);
        cmp("rst result", bus.result, 32'd0);
        ops[idx].end_at = cyc;
        repeat (2) tick();
        rst = 1'b0;
        run_dir("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit for the RV32M extension. It sits in the execute stage beside the single-cycle ALU. Decode issues an M-type operation with a one-cycle `start` pulse. The pipeline stalls on `busy`. The result is written back in the cycle `done` pulses. Multiplies use radix-2 shift-add and divides use restoring division, both over LEN iterations, with sign fix-up in a final cycle.

## Interface
- `LEN`, default 32: operand and result width.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: issue request; sampled only in IDLE or DONE.
- `op` in 3: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1` in LEN: rs1 value; captured with `start`.
- `op2` in LEN: rs2 value; captured with `start`.
- `flush` in 1: synchronous abort from branch mispredict or trap.
- `busy` out 1: unit is computing; the pipeline must stall.
- `done` out 1: single-cycle pulse; `result` is valid in this cycle.
- `result` out LEN: result register; holds its value until the next `done`.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE/DONE, `start` high:**
  - Latch `op`.
  - Latch the operand magnitudes: two's-complement absolute value for signed operands. MULH and DIV/REM treat both operands as signed. MULHSU treats only `op1` as signed.
  - Latch a negate flag:
    - MULH: sign(op1) XOR sign(op2).
    - MULHSU: sign(op1).
    - DIV: sign(op1) XOR sign(op2).
    - REM: sign(op1).
    - Unsigned ops: 0.
  - Clear the iteration counter and go to CALC.
- **CALC:** exactly LEN iterations, counter 0..LEN-1.
  - Multiply: 2·LEN-bit accumulator. Add the multiplicand when the current multiplier bit is 1, then shift.
  - Divide: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
  - Go to FIX when the counter reaches LEN-1.
- **FIX:**
  - Conditionally negate the 2·LEN-bit product, the quotient or the remainder.
  - Select the output: MUL takes the low LEN bits; MULH/MULHSU/MULHU take the high LEN bits.
  - Apply the special cases, which override the iterative result:
    - Divide by zero (`op2`==0): DIV/DIVU give all ones; REM/REMU give `op1`.
    - Signed overflow (DIV/REM with `op1`=0x8000_0000, `op2`=0xFFFF_FFFF): DIV gives 0x8000_0000; REM gives 0.
  - Latch `result` and go to DONE.
- **DONE:** `done`=1 for exactly one cycle.
  - With `start` high, begin a new operation (back-to-back issue).
  - Otherwise go to IDLE.
- **`start` outside IDLE/DONE:** ignored.
- **`flush`:**
  - In CALC or FIX: go to IDLE next edge; `done` is not pulsed and `result` is unchanged.
  - In DONE: `done` still pulses in that cycle, and `start` in the same cycle is ignored.
  - Flush takes priority over `start`.
- **Width rules:**
  - Magnitudes are LEN-bit unsigned; 0x8000_0000 negates to itself and is read as 2^31.
  - The product accumulator is 2·LEN bits; the remainder register is LEN+1 bits.

## Timing
- **Reset values:** state IDLE; `busy`=0, `done`=0, `result`=0; counter 0.
- **Latency:** if `start` is accepted at edge k:
  - `busy`=1 in cycles k+1 … k+LEN+1 (CALC and FIX).
  - `done`=1 in cycle k+LEN+2 with `result` valid.
  - Total latency is LEN+2 cycles (34 at LEN=32) for every op, including the special cases.
- **`busy`** is a registered decode of state, CALC or FIX; it is 0 in IDLE and DONE.
- **Throughput:** one operation per LEN+2 cycles with back-to-back `start` in DONE.
- **Reset mid-operation:** immediately returns to IDLE with all outputs at their reset values; no `done`.
- **Operand capture:** `op1`, `op2` and `op` may change after the accept edge without affecting the result.

## Test plan
- **MUL:** MUL 7 × -3 (0x0000_0007, 0xFFFF_FFFD) → `done` at cycle k+34 with `result`=0xFFFF_FFEB. `busy` is high for exactly 33 cycles.
- **High-half products:** for 0xFFFF_FFFF × 0xFFFF_FFFF:
  - MULHU → 0xFFFF_FFFE.
  - MULH → 0x0000_0000.
  - MULHSU → 0xFFFF_FFFF.
  - MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000.
- **Signed divide:**
  - DIV -7/2 → 0xFFFF_FFFD.
  - REM -7/2 → 0xFFFF_FFFF.
  - DIVU 0xFFFF_FFF9/2 → 0x7FFF_FFFC.
  - REMU 0xFFFF_FFF9/2 → 1.
- **Special cases:**
  - DIV 5/0 → 0xFFFF_FFFF; REMU 5/0 → 5.
  - DIV 0x8000_0000/-1 → 0x8000_0000; REM of the same operands → 0.
  - Latency is still 34 cycles in every case.
- **Control:**
  - `start` held high through an operation → exactly one `done` per accept, and back-to-back ops complete 34 cycles apart.
  - `flush` asserted at cycle k+10 → IDLE at k+11, no `done`, `result` unchanged.
- **Reset:** async `rst` asserted mid-CALC, between clock edges → `busy`, `done` and `result` go to 0 immediately. After release, a new DIVU 100/7 returns 14.
